// File: rtl/game_flow_ctrl.sv
// ----------------------------------------------------------------------------
// game_flow_ctrl
//
// Game-flow FSM (START / MAZE / BATTLE / END) with a lives counter, plus a
// video-source selector that routes one of NUM_SRC screen generators to the
// VGA pins. The selected source changes only on frame_start, so a switch
// never tears a frame.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   frame_start         1-cycle pulse at the start of each frame
//   start_req           start/continue request (level, rising edge used)
//   restart_req         restart request (level, rising edge used)
//   enemy_collide       maze -> battle trigger (level, rising edge used)
//   battle_won          battle won (level, rising edge used)
//   battle_lost         battle lost (level, rising edge used)
//   game_won            final boss defeated (level, rising edge used)
//   src_r/g/b           packed colour per source, source i at [i*W +: W]
//   src_hs/src_vs       sync per source
//   r, g, b, hs, vs     registered VGA outputs of the selected source
//   game_state          0 START, 1 MAZE, 2 BATTLE, 3 END (FSM state, debug)
//   disp_sel            source currently on screen
//   lives               remaining lives
//   win_flag            1 = END reached by game_won, 0 = by lives exhausted
//   state_chg           1-cycle pulse whenever game_state takes a new value
//
// Event semantics: every event input is a level. It is registered once, and
// only its rising edge (registered value high, previous registered value low)
// acts on the FSM, so a held level triggers exactly one transition.
// ----------------------------------------------------------------------------
module game_flow_ctrl #(
    parameter int NUM_SRC         = 4,
    parameter int R_W             = 3,
    parameter int G_W             = 3,
    parameter int B_W             = 2,
    parameter int LIVES           = 3,
    parameter int END_HOLD_FRAMES = 120,
    parameter bit SYNC_IDLE       = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       start_req,
    input  logic                       restart_req,
    input  logic                       enemy_collide,
    input  logic                       battle_won,
    input  logic                       battle_lost,
    input  logic                       game_won,
    input  logic [NUM_SRC*R_W-1:0]     src_r,
    input  logic [NUM_SRC*G_W-1:0]     src_g,
    input  logic [NUM_SRC*B_W-1:0]     src_b,
    input  logic [NUM_SRC-1:0]         src_hs,
    input  logic [NUM_SRC-1:0]         src_vs,
    output logic [R_W-1:0]             r,
    output logic [G_W-1:0]             g,
    output logic [B_W-1:0]             b,
    output logic                       hs,
    output logic                       vs,
    output logic [1:0]                 game_state,
    output logic [$clog2(NUM_SRC)-1:0] disp_sel,
    output logic [3:0]                 lives,
    output logic                       win_flag,
    output logic                       state_chg
);

    localparam int SEL_W  = $clog2(NUM_SRC);
    localparam int HOLD_W = $clog2(END_HOLD_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_MAZE   = 2'd1,
        ST_BATTLE = 2'd2,
        ST_END    = 2'd3
    } state_t;

    // Event bit positions inside the registered event vector
    localparam int EV_START   = 0;
    localparam int EV_RESTART = 1;
    localparam int EV_COLLIDE = 2;
    localparam int EV_WON     = 3;
    localparam int EV_LOST    = 4;
    localparam int EV_GAMEWON = 5;

    logic [5:0]        ev_q, ev_prev, ev_rise;
    state_t            state_q, state_d;
    logic [3:0]        lives_q, lives_d;
    logic              win_q, win_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [R_W-1:0]    r_mux;
    logic [G_W-1:0]    g_mux;
    logic [B_W-1:0]    b_mux;
    logic              hs_mux, vs_mux;

    assign ev_rise = ev_q & ~ev_prev;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_q      <= '0;
            ev_prev   <= '0;
            state_q   <= ST_START;
            lives_q   <= 4'(LIVES);
            win_q     <= 1'b0;
            hold_q    <= '0;
            state_chg <= 1'b0;
        end else begin
            ev_q      <= {game_won, battle_lost, battle_won,
                          enemy_collide, restart_req, start_req};
            ev_prev   <= ev_q;
            state_q   <= state_d;
            lives_q   <= lives_d;
            win_q     <= win_d;
            hold_q    <= hold_d;
            // Rises together with the new game_state value
            state_chg <= (state_d != state_q);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        win_d   = win_q;
        hold_d  = hold_q;

        if (ev_rise[EV_RESTART]) begin
            // Restart beats every other event in every state
            state_d = ST_START;
            lives_d = 4'(LIVES);
            win_d   = 1'b0;
        end else begin
            case (state_q)
                ST_START: begin
                    if (ev_rise[EV_START]) begin
                        state_d = ST_MAZE;
                        lives_d = 4'(LIVES);
                        win_d   = 1'b0;
                    end
                end
                ST_MAZE: begin
                    if (ev_rise[EV_COLLIDE]) state_d = ST_BATTLE;
                end
                ST_BATTLE: begin
                    if (ev_rise[EV_GAMEWON]) begin
                        state_d = ST_END;
                        win_d   = 1'b1;
                    end else if (ev_rise[EV_LOST]) begin
                        if (lives_q > 4'd1) begin
                            lives_d = lives_q - 4'd1;
                            state_d = ST_MAZE;
                        end else begin
                            lives_d = 4'd0;
                            state_d = ST_END;
                            win_d   = 1'b0;
                        end
                    end else if (ev_rise[EV_WON]) begin
                        state_d = ST_MAZE;
                    end
                end
                ST_END: begin
                    if (frame_start) begin
                        if (hold_q == HOLD_W'(END_HOLD_FRAMES - 1)) begin
                            state_d = ST_START;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_START;
            endcase
        end

        // Each visit to END starts counting frames from zero
        if (state_d == ST_END && state_q != ST_END) hold_d = '0;
    end

    // ------------------------------------------------------------------
    // Source mux: combinational select, registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        r_mux  = '0;
        g_mux  = '0;
        b_mux  = '0;
        hs_mux = SYNC_IDLE;
        vs_mux = SYNC_IDLE;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (disp_sel == SEL_W'(i)) begin
                r_mux  = src_r[i*R_W +: R_W];
                g_mux  = src_g[i*G_W +: G_W];
                b_mux  = src_b[i*B_W +: B_W];
                hs_mux = src_hs[i];
                vs_mux = src_vs[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_sel <= '0;
            r        <= '0;
            g        <= '0;
            b        <= '0;
            hs       <= SYNC_IDLE;
            vs       <= SYNC_IDLE;
        end else begin
            // Samples the state held before this edge, so a state change on a
            // frame_start cycle reaches the screen one frame later
            if (frame_start) disp_sel <= SEL_W'(state_q);
            r  <= r_mux;
            g  <= g_mux;
            b  <= b_mux;
            hs <= hs_mux;
            vs <= vs_mux;
        end
    end

    assign game_state = state_q;
    assign lives      = lives_q;
    assign win_flag   = win_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// ----------------------------------------------------------------------------
// tb_game_flow_ctrl
//
// Directed bench for game_flow_ctrl with END_HOLD_FRAMES = 4. Each source i
// drives red = i, green = i+4, blue = 3-i, hsync = bit i of 4'b0101 and
// vsync = bit i of 4'b0011, so the outputs identify the selected source.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_game_flow_ctrl;

    localparam int NUM_SRC = 4;
    localparam int R_W = 3;
    localparam int G_W = 3;
    localparam int B_W = 2;

    logic clk = 1'b0;
    logic rst;
    logic frame_start, start_req, restart_req, enemy_collide;
    logic battle_won, battle_lost, game_won;
    logic [NUM_SRC*R_W-1:0] src_r;
    logic [NUM_SRC*G_W-1:0] src_g;
    logic [NUM_SRC*B_W-1:0] src_b;
    logic [NUM_SRC-1:0]     src_hs, src_vs;
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
    logic hs, vs;
    logic [1:0] game_state;
    logic [1:0] disp_sel;
    logic [3:0] lives;
    logic win_flag, state_chg;

    int tests_run = 0;
    int tests_failed = 0;

    game_flow_ctrl #(
        .NUM_SRC(NUM_SRC), .R_W(R_W), .G_W(G_W), .B_W(B_W),
        .LIVES(3), .END_HOLD_FRAMES(4), .SYNC_IDLE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .start_req(start_req), .restart_req(restart_req),
        .enemy_collide(enemy_collide), .battle_won(battle_won),
        .battle_lost(battle_lost), .game_won(game_won),
        .src_r(src_r), .src_g(src_g), .src_b(src_b),
        .src_hs(src_hs), .src_vs(src_vs),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs),
        .game_state(game_state), .disp_sel(disp_sel), .lives(lives),
        .win_flag(win_flag), .state_chg(state_chg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    // Collide edge from MAZE: registered at the first edge, acted on at the second
    task automatic do_collide();
        enemy_collide = 1'b1;
        tick(2);
        enemy_collide = 1'b0;
        check("collide_state", 32'(game_state), 32'd2);
        tick(1);
    endtask

    task automatic do_start();
        start_req = 1'b1;
        tick(2);
        start_req = 1'b0;
        check("start_state", 32'(game_state), 32'd1);
        check("start_lives", 32'(lives), 32'd3);
        tick(1);
    endtask

    initial begin
        // Sources
        for (int i = 0; i < NUM_SRC; i++) begin
            src_r[i*R_W +: R_W] = R_W'(i);
            src_g[i*G_W +: G_W] = G_W'(i + 4);
            src_b[i*B_W +: B_W] = B_W'(3 - i);
        end
        src_hs = 4'b0101;
        src_vs = 4'b0011;
        frame_start = 0; start_req = 0; restart_req = 0; enemy_collide = 0;
        battle_won = 0; battle_lost = 0; game_won = 0;

        // Reset
        rst = 1'b1;
        tick(2);
        check("rst_state", 32'(game_state), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_hs", 32'(hs), 32'd1);
        check("rst_r", 32'(r), 32'd0);
        rst = 1'b0;
        tick(1);
        check("src0_g", 32'(g), 32'd4);
        check("src0_b", 32'(b), 32'd3);
        check("rst_disp_sel", 32'(disp_sel), 32'd0);
        check("rst_chg", 32'(state_chg), 32'd0);

        // Held start request moves exactly one state
        start_req = 1'b1;
        tick(1);
        check("start_lat1", 32'(game_state), 32'd0);
        tick(1);
        check("start_maze", 32'(game_state), 32'd1);
        check("start_chg", 32'(state_chg), 32'd1);
        tick(1);
        check("start_chg_end", 32'(state_chg), 32'd0);
        tick(1000);
        check("start_hold", 32'(game_state), 32'd1);
        check("sel_wait_frame", 32'(disp_sel), 32'd0);
        start_req = 1'b0;
        frame_pulse();
        check("sel_after_frame", 32'(disp_sel), 32'd1);
        check("r_lat", 32'(r), 32'd0);
        tick(1);
        check("src1_r", 32'(r), 32'd1);
        check("src1_g", 32'(g), 32'd5);
        check("src1_b", 32'(b), 32'd2);
        check("src1_hs", 32'(hs), 32'd0);
        check("src1_vs", 32'(vs), 32'd1);

        // Battle won returns to MAZE with lives intact
        do_collide();
        battle_won = 1'b1;
        tick(2);
        battle_won = 1'b0;
        check("won_state", 32'(game_state), 32'd1);
        check("won_lives", 32'(lives), 32'd3);
        tick(1);

        // Three losses: lives 2, 1, 0; last one ends the game
        for (int k = 0; k < 3; k++) begin
            do_collide();
            battle_lost = 1'b1;
            tick(2);
            battle_lost = 1'b0;
            check("loss_lives", 32'(lives), 32'(2 - k));
            check("loss_state", 32'(game_state), (k == 2) ? 32'd3 : 32'd1);
            check("loss_chg", 32'(state_chg), 32'd1);
            tick(1);
        end
        check("loss_win", 32'(win_flag), 32'd0);

        // END holds for 4 frames then returns to START
        for (int k = 0; k < 3; k++) frame_pulse();
        check("hold_3", 32'(game_state), 32'd3);
        check("hold_sel", 32'(disp_sel), 32'd3);
        frame_pulse();
        check("hold_4", 32'(game_state), 32'd0);
        check("hold_sel_late", 32'(disp_sel), 32'd3);
        check("hold_chg", 32'(state_chg), 32'd1);
        tick(1);
        check("src3_r", 32'(r), 32'd3);
        check("src3_b", 32'(b), 32'd0);

        // game_won beats battle_won in the same cycle
        do_start();
        do_collide();
        battle_won = 1'b1;
        game_won = 1'b1;
        tick(2);
        battle_won = 1'b0;
        game_won = 1'b0;
        check("gw_state", 32'(game_state), 32'd3);
        check("gw_win", 32'(win_flag), 32'd1);
        check("gw_lives", 32'(lives), 32'd3);
        tick(1);

        // Restart during END hold
        frame_pulse();
        frame_pulse();
        check("rs_pre", 32'(game_state), 32'd3);
        restart_req = 1'b1;
        tick(2);
        restart_req = 1'b0;
        check("rs_state", 32'(game_state), 32'd0);
        check("rs_win", 32'(win_flag), 32'd0);
        check("rs_lives", 32'(lives), 32'd3);
        tick(1);

        // Restart overrides a same-cycle battle loss
        do_start();
        do_collide();
        battle_lost = 1'b1;
        restart_req = 1'b1;
        tick(2);
        battle_lost = 1'b0;
        restart_req = 1'b0;
        check("rsp_state", 32'(game_state), 32'd0);
        check("rsp_lives", 32'(lives), 32'd3);
        tick(1);

        // Asynchronous reset in the middle of a frame
        do_start();
        frame_pulse();
        tick(1);
        check("pre_rst_r", 32'(r), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_r", 32'(r), 32'd0);
        check("arst_g", 32'(g), 32'd0);
        check("arst_hs", 32'(hs), 32'd1);
        check("arst_vs", 32'(vs), 32'd1);
        check("arst_state", 32'(game_state), 32'd0);
        check("arst_sel", 32'(disp_sel), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
